uart_tx_buf: RTL and testbench

//  Byte buffer and pacing stage sitting directly upstream of the UART transmitter.
//  - Accepts bytes from system logic into a synchronous FIFO.
//  - Issues one-cycle tx_trig/uart_tx strobes to the transmitter, one byte per frame.
//  - The transmitter has no busy output, so this block times each frame itself.
//    It waits a full 10-bit frame (start + 8 data + stop) before issuing the next byte.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_buf_sync_fifo.sv | 50 +++++
 rtl/uart_tx_buf.sv | 90 +++++++++
 tb/tb_uart_tx_buf.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants and transmit FSM state type.
// Defining SIM shortens the bit period so frames are short in simulation.
package uart_pkg;
`ifdef SIM
    localparam int BAUD_END = 56;
`else
    localparam int BAUD_END = 5207;
`endif
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_state_t;

    function automatic int frame_cycles(input int baud_end);
        return FRAME_BITS * (baud_end + 1);
    endfunction
endpackage

// File: rtl/uart_tx_buf_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; shared by the TX and future RX buffers.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr,
    input  logic         i_rd,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty,
    output logic [AW:0]  o_level
);
    localparam logic [AW:0] L_ONE = 1;
    localparam logic [AW:0] L_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_level == L_MAX);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rp];
    // A full FIFO drops the write even when a read frees a slot on the same edge.
    assign w_wr    = i_wr && !o_full;
    assign w_rd    = i_rd && !o_empty;

    always_ff @(posedge i_clk)
        if (w_wr) r_mem[r_wp] <= i_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            r_wp    <= w_wr ? r_wp + AW'(1) : r_wp;
            r_rp    <= w_rd ? r_rp + AW'(1) : r_rp;
            r_level <= (w_wr && !w_rd) ? r_level + L_ONE :
                       (w_rd && !w_wr) ? r_level - L_ONE : r_level;
        end
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffers bytes and paces them one frame apart into a busy-less UART transmitter.
// Define UART_TXBUF_OVF_EN to add a sticky overflow flag (ovf_err) with clear input (ovf_clr).
module uart_tx_buf #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int BAUD_END = uart_pkg::BAUD_END
) (
    input  logic        sclk,
    input  logic        s_rst_n,
`ifdef UART_TXBUF_OVF_EN
    input  logic        ovf_clr,
    output logic        ovf_err,
`endif
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        tx_trig,
    output logic [7:0]  uart_tx,
    output logic        tx_busy
);
    import uart_pkg::*;

    localparam int            FRAME_CYC = frame_cycles(BAUD_END);
    localparam int            CW        = $clog2(FRAME_CYC);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(FRAME_CYC - 1);

    tx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_tx_trig;
    logic [7:0]    r_uart_tx;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic [7:0]    w_head;

    assign w_pop   = (r_state == IDLE) && !w_empty;
    assign full    = w_full;
    assign empty   = w_empty;
    assign tx_trig = r_tx_trig;
    assign uart_tx = r_uart_tx;
    assign tx_busy = (r_state != IDLE);

    sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(8)) u_fifo (
        .i_clk   (sclk),
        .i_rst_n (s_rst_n),
        .i_wr    (wr_en),
        .i_rd    (w_pop),
        .i_wdata (wr_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // LOAD and the IDLE pop cycle add two cycles on top of the frame, giving the pulse spacing.
    always_ff @(posedge sclk or negedge s_rst_n)
        if (!s_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tx_trig <= 1'b0;
            r_uart_tx <= 8'h00;
        end else begin
            r_tx_trig <= w_pop;
            r_uart_tx <= w_pop ? w_head : r_uart_tx;
            case (r_state)
                IDLE: r_state <= w_pop ? LOAD : IDLE;
                LOAD: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
                    r_state <= (r_cnt == '0) ? IDLE : WAIT;
                end
                default: r_state <= IDLE;
            endcase
        end

`ifdef UART_TXBUF_OVF_EN
    logic r_ovf;

    always_ff @(posedge sclk or negedge s_rst_n)
        if (!s_rst_n) r_ovf <= 1'b0;
        else          r_ovf <= ovf_clr ? 1'b0 : (wr_en && w_full) ? 1'b1 : r_ovf;

    assign ovf_err = r_ovf;
`endif
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed + randomized bench with a queue/timeline reference model.
// Runs with BAUD_END=56 (570-cycle frames); checks ovf_err when UART_TXBUF_OVF_EN is defined.
module tb_uart_tx_buf;
    localparam int FR  = 570;
    localparam int GAP = FR + 2;

    logic       sclk    = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, tx_trig, tx_busy;
    logic [4:0] level;
    logic [7:0] uart_tx;
`ifdef UART_TXBUF_OVF_EN
    logic       ovf_clr = 1'b0;
    logic       ovf_err;
`endif

    int         tests    = 0;
    int         fails    = 0;
    int         edge_n   = 0;
    int         last_pop = -100000;
    logic [7:0] last_tx  = 8'h00;
    bit         m_ovf    = 1'b0;
    logic [7:0] q[$];
    logic [7:0] tq[$];
    logic [7:0] wq[$];
    int         te[$];

    always #5 sclk = ~sclk;

    uart_tx_buf #(.DEPTH(16), .AW(4), .BAUD_END(56)) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
`ifdef UART_TXBUF_OVF_EN
        .ovf_clr (ovf_clr),
        .ovf_err (ovf_err),
`endif
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .tx_trig (tx_trig),
        .uart_tx (uart_tx),
        .tx_busy (tx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from the byte queue and the time of the last pop.
    task automatic check_all();
        int d;
        d = edge_n - last_pop;
        chk("tx_trig", 32'(tx_trig), 32'(d == 0));
        chk("tx_busy", 32'(tx_busy), 32'(d >= 0 && d <= FR));
        chk("uart_tx", 32'(uart_tx), 32'(last_tx));
        chk("level",   32'(level),   32'(q.size()));
        chk("full",    32'(full),    32'(q.size() == 16));
        chk("empty",   32'(empty),   32'(q.size() == 0));
`ifdef UART_TXBUF_OVF_EN
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
`endif
    endtask

    task automatic step(input bit we, input logic [7:0] d, input bit clr = 1'b0);
        int sz;
        wr_en   = we;
        wr_data = d;
`ifdef UART_TXBUF_OVF_EN
        ovf_clr = clr;
`endif
        @(posedge sclk);
        edge_n++;
        if (s_rst_n) begin
            sz = q.size();
            m_ovf = clr ? 1'b0 : (we && sz == 16) ? 1'b1 : m_ovf;
            if (sz > 0 && edge_n - last_pop >= GAP) begin
                last_tx  = q.pop_front();
                last_pop = edge_n;
            end
            if (we && sz < 16) q.push_back(d);
        end
        #1;
        check_all();
        if (tx_trig === 1'b1) begin
            te.push_back(edge_n);
            tq.push_back(uart_tx);
        end
        wr_en = 1'b0;
`ifdef UART_TXBUF_OVF_EN
        ovf_clr = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic do_reset(input int hold);
        s_rst_n = 1'b0;
        #1;
        q.delete();
        last_pop = -100000;
        last_tx  = 8'h00;
        m_ovf    = 1'b0;
        check_all();
        chk("rst_trig",  32'(tx_trig), 32'd0);
        chk("rst_busy",  32'(tx_busy), 32'd0);
        chk("rst_data",  32'(uart_tx), 32'h00);
        chk("rst_level", 32'(level),   32'd0);
        chk("rst_empty", 32'(empty),   32'd1);
        chk("rst_full",  32'(full),    32'd0);
        idle(hold);
        s_rst_n = 1'b1;
    endtask

    initial begin
        int b;
        logic [7:0] v;
        #3;
        do_reset(3);

        // 1: single byte latency and busy duration
        te.delete(); tq.delete();
        step(1'b1, 8'hA5);
        step(1'b0, 8'h00);
        chk("t1_trig", 32'(tx_trig), 32'd1);
        chk("t1_data", 32'(uart_tx), 32'hA5);
        b = (tx_busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 600; i++) begin
            step(1'b0, 8'h00);
            b += (tx_busy === 1'b1) ? 1 : 0;
        end
        chk("t1_busy_cycles", 32'(b), 32'd571);
        chk("t1_pulses", 32'(te.size()), 32'd1);

        // 2: three back-to-back bytes
        te.delete(); tq.delete();
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        idle(3 * GAP);
        chk("t2_pulses", 32'(te.size()), 32'd3);
        if (te.size() == 3) begin
            chk("t2_b0",   32'(tq[0]), 32'h11);
            chk("t2_b1",   32'(tq[1]), 32'h22);
            chk("t2_b2",   32'(tq[2]), 32'h33);
            chk("t2_gap1", 32'(te[1] - te[0]), 32'(GAP));
            chk("t2_gap2", 32'(te[2] - te[1]), 32'(GAP));
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: overfill while the frame timer runs
        step(1'b1, 8'($urandom));
        step(1'b0, 8'h00);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'($urandom));
            if (i == 15) begin
                chk("t3_full16",  32'(full),  32'd1);
                chk("t3_level16", 32'(level), 32'd16);
            end
        end
        chk("t3_level17", 32'(level), 32'd16);
`ifdef UART_TXBUF_OVF_EN
        chk("t3_ovf_set", 32'(ovf_err), 32'd1);
`endif
        step(1'b1, 8'($urandom), 1'b1);
`ifdef UART_TXBUF_OVF_EN
        chk("t3_ovf_clr_wins", 32'(ovf_err), 32'd0);
`endif
        idle(17 * GAP + 10);

        // 4: write on the same edge as a pop at level 5
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
        while (edge_n + 1 < last_pop + GAP) step(1'b0, 8'h00);
        step(1'b1, 8'($urandom));
        chk("t4_trig",  32'(tx_trig), 32'd1);
        chk("t4_level", 32'(level),   32'd5);
        idle(6 * GAP + 10);

        // 5: reset 200 cycles into a frame with 4 bytes queued
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
        chk("t5_level", 32'(level), 32'd4);
        while (edge_n < last_pop + 200) step(1'b0, 8'h00);
        do_reset(2);
        te.delete(); tq.delete();
        idle(1200);
        chk("t5_no_trig", 32'(te.size()), 32'd0);

        // 6: randomized stream across pointer wrap
        te.delete(); tq.delete(); wq.delete();
        for (int i = 0; i < 40; i++) begin
            v = 8'($urandom);
            wq.push_back(v);
            step(1'b1, v);
            idle($urandom_range(400, 800));
        end
        idle(14 * GAP);
        chk("t6_count", 32'(tq.size()), 32'd40);
        if (tq.size() == 40)
            for (int i = 0; i < 40; i++) chk("t6_order", 32'(tq[i]), 32'(wq[i]));
        for (int i = 1; i < te.size(); i++)
            chk("t6_spacing_min", 32'(te[i] - te[i-1] >= GAP), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
